// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: datapath stage fields in, forwarding selects and stall/flush enables out.
// The datapath side uses the master modport; the hazard controller uses the slave modport.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 4
);
  logic [REG_W-1:0] RA1D;
  logic [REG_W-1:0] RA2D;
  logic [REG_W-1:0] RA1E;
  logic [REG_W-1:0] RA2E;
  logic [REG_W-1:0] WA3E;
  logic             MemtoRegE;
  logic [REG_W-1:0] WA3M;
  logic             RegWriteM;
  logic             MemReqM;
  logic             MemReady;
  logic [REG_W-1:0] WA3W;
  logic             RegWriteW;
  logic             PCSrcW;

  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             FlushW;
  logic             MemAbort;
  logic             mem_err;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, MemtoRegE, WA3M, RegWriteM,
           MemReqM, MemReady, WA3W, RegWriteW, PCSrcW,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, MemAbort, mem_err
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, MemtoRegE, WA3M, RegWriteM,
           MemReqM, MemReady, WA3W, RegWriteW, PCSrcW,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, MemAbort, mem_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage F/D/E/M/W pipeline: forwarding, load-use stall,
// data-memory wait with timeout, W-stage branch squash. Macro HAZARD_PERF_EN adds state-cycle counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]     ld_stall_cnt,
  output logic [CNT_W-1:0]     mem_wait_cnt,
  output logic [CNT_W-1:0]     squash_cnt
`endif
);

  localparam logic [REG_W-1:0] PC_REG    = REG_W'(15);
  localparam int               WC_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_SQUASH  = 2'd3
  } state_t;

  state_t          r_state;
  logic [WC_W-1:0] r_wait_cnt;
  logic            r_mem_err;

  state_t          w_state_next;
  logic [WC_W-1:0] w_wait_next;
  logic            w_err_set;
  logic [3:0]      w_stall;     // {M, E, D, F}
  logic [3:0]      w_flush;     // {W, M, E, D}
  logic            w_mem_abort;
  logic            w_mem_pending;
  logic            w_timeout;
  logic            w_mem_hold;
  logic            w_load_use;

  // Forwarding: one selector per E-stage source operand; M result wins over W result.
  logic [REG_W-1:0] w_src_e [2];
  logic [1:0]       w_fwd   [2];

  assign w_src_e[0] = hz.RA1E;
  assign w_src_e[1] = hz.RA2E;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign w_fwd[gi] =
        (!reset_n || (w_src_e[gi] == PC_REG))           ? 2'b00 :
        (hz.RegWriteM && (hz.WA3M == w_src_e[gi]))      ? 2'b10 :
        (hz.RegWriteW && (hz.WA3W == w_src_e[gi]))      ? 2'b01 :
                                                          2'b00;
    end
  endgenerate

  assign hz.ForwardAE = w_fwd[0];
  assign hz.ForwardBE = w_fwd[1];

  assign w_mem_pending = hz.MemReqM && !hz.MemReady;
  assign w_timeout     = w_mem_pending && (r_wait_cnt == WAIT_LAST);
  assign w_mem_hold    = w_mem_pending && !w_timeout;
  // A hazard seen while already stalled (load-use or memory wait) gets no second bubble.
  assign w_load_use    = hz.MemtoRegE && (hz.WA3E != PC_REG) &&
                         ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D)) &&
                         (r_state != ST_LDSTALL) && (r_state != ST_MEMWAIT);

  always_comb begin
    w_stall      = 4'b0000;
    w_flush      = 4'b0000;
    w_mem_abort  = 1'b0;
    w_state_next = ST_RUN;
    w_wait_next  = '0;
    w_err_set    = 1'b0;
    if (!reset_n) begin
      w_flush = 4'b1111;
    end else begin
      if (r_state == ST_SQUASH) begin
        w_flush[0] = 1'b1;
      end
      if (hz.PCSrcW) begin
        w_flush[2:0] = 3'b111;
        w_mem_abort  = (r_state == ST_MEMWAIT) || hz.MemReqM;
        w_state_next = ST_SQUASH;
      end else if (w_mem_hold) begin
        w_stall      = 4'b1111;
        w_flush[3]   = 1'b1;
        w_state_next = ST_MEMWAIT;
        w_wait_next  = r_wait_cnt + 1'b1;
      end else begin
        // A timed-out access is released exactly as if the memory had answered.
        w_err_set = w_timeout;
        if (w_load_use) begin
          w_stall[1:0] = 2'b11;
          w_flush[1]   = 1'b1;
          w_state_next = ST_LDSTALL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      if (w_err_set) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign hz.StallF   = w_stall[0];
  assign hz.StallD   = w_stall[1];
  assign hz.StallE   = w_stall[2];
  assign hz.StallM   = w_stall[3];
  assign hz.FlushD   = w_flush[0];
  assign hz.FlushE   = w_flush[1];
  assign hz.FlushM   = w_flush[2];
  assign hz.FlushW   = w_flush[3];
  assign hz.MemAbort = w_mem_abort;
  assign hz.mem_err  = r_mem_err;

`ifdef HAZARD_PERF_EN
  // Saturating per-state cycle counters, index order: LDSTALL, MEMWAIT, SQUASH.
  logic [2:0] w_in_state;
  assign w_in_state[0] = (r_state == ST_LDSTALL);
  assign w_in_state[1] = (r_state == ST_MEMWAIT);
  assign w_in_state[2] = (r_state == ST_SQUASH);

  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else if (w_in_state[gi] && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  assign ld_stall_cnt = g_perf[0].r_cnt;
  assign mem_wait_cnt = g_perf[1].r_cnt;
  assign squash_cnt   = g_perf[2].r_cnt;
`else
  // The counter width only matters when the counters exist; still reject a nonsensical value.
  generate
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
    end
  endgenerate
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a rule-level model checks every cycle, literal pins anchor it.
module tb_pipeline_hazard_ctrl;

  localparam int MT = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(4)) hz ();

`ifdef HAZARD_PERF_EN
  logic [15:0] ld_stall_cnt, mem_wait_cnt, squash_cnt;
`endif

  pipeline_hazard_ctrl #(
    .REG_W(4), .MEM_TIMEOUT(MT), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hz(hz)
`ifdef HAZARD_PERF_EN
    ,
    .ld_stall_cnt(ld_stall_cnt),
    .mem_wait_cnt(mem_wait_cnt),
    .squash_cnt(squash_cnt)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  // Model state, in terms of what happened on previous cycles.
  int m_wait = 0;       // consecutive memory-wait stall cycles so far
  bit m_squash = 0;     // a redirect was taken last cycle
  bit m_ld = 0;         // a load-use bubble was inserted last cycle
  bit m_err = 0;

  // Last observed DUT outputs, for literal pins.
  logic [1:0] o_fa, o_fb;
  logic [3:0] o_stall, o_flush;
  logic       o_abort, o_err;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [1:0] exp_fwd(input logic [3:0] src);
    if (!reset_n || src == 4'd15) return 2'b00;
    if (hz.RegWriteM && hz.WA3M == src) return 2'b10;
    if (hz.RegWriteW && hz.WA3W == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle_inputs();
    hz.RA1D = 0; hz.RA2D = 0; hz.RA1E = 0; hz.RA2E = 0; hz.WA3E = 0;
    hz.MemtoRegE = 0; hz.WA3M = 0; hz.RegWriteM = 0; hz.MemReqM = 0;
    hz.MemReady = 0; hz.WA3W = 0; hz.RegWriteW = 0; hz.PCSrcW = 0;
  endtask

  // One pipeline cycle: evaluate rules, compare, then advance past the clock edge.
  task automatic cyc(input string tag);
    bit mem_hold, mem_release, ld;
    logic [3:0] e_stall, e_flush;
    bit e_abort;
    #1;
    e_stall = 4'b0; e_flush = 4'b0; e_abort = 0;
    mem_hold    = hz.MemReqM && !hz.MemReady && (m_wait < MT - 1);
    mem_release = hz.MemReqM && !hz.MemReady && (m_wait == MT - 1);
    ld = hz.MemtoRegE && hz.WA3E != 4'd15 && (hz.WA3E == hz.RA1D || hz.WA3E == hz.RA2D)
         && !m_ld && m_wait == 0;
    if (!reset_n) begin
      e_flush = 4'b1111;
    end else begin
      if (m_squash) e_flush[0] = 1'b1;
      if (hz.PCSrcW) begin
        e_flush = e_flush | 4'b0111;
        e_abort = (m_wait > 0) || hz.MemReqM;
      end else if (mem_hold) begin
        e_stall = 4'b1111;
        e_flush = e_flush | 4'b1000;
      end else if (ld) begin
        e_stall = 4'b0011;
        e_flush = e_flush | 4'b0010;
      end
    end
    o_fa = hz.ForwardAE; o_fb = hz.ForwardBE;
    o_stall = {hz.StallM, hz.StallE, hz.StallD, hz.StallF};
    o_flush = {hz.FlushW, hz.FlushM, hz.FlushE, hz.FlushD};
    o_abort = hz.MemAbort; o_err = hz.mem_err;
    check({tag, ".fwdA"}, int'(o_fa), int'(exp_fwd(hz.RA1E)));
    check({tag, ".fwdB"}, int'(o_fb), int'(exp_fwd(hz.RA2E)));
    check({tag, ".stall"}, int'(o_stall), int'(e_stall));
    check({tag, ".flush"}, int'(o_flush), int'(e_flush));
    check({tag, ".abort"}, int'(o_abort), int'(e_abort));
    check({tag, ".err"}, int'(o_err), int'(m_err));
    $display("t=%0t %s rst_n=%0b fa=%0b fb=%0b stall=%b flush=%b abort=%0b err=%0b",
             $time, tag, reset_n, o_fa, o_fb, o_stall, o_flush, o_abort, o_err);
    @(posedge clk);
    if (!reset_n) begin
      m_wait = 0; m_squash = 0; m_ld = 0; m_err = 0;
    end else begin
      m_squash = hz.PCSrcW;
      m_ld     = !hz.PCSrcW && !mem_hold && ld;
      m_wait   = (!hz.PCSrcW && mem_hold) ? m_wait + 1 : 0;
      if (!hz.PCSrcW && mem_release) m_err = 1;
    end
    #1;
  endtask

  int cnt;

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clk); #1;
    cyc("rst0");
    cyc("rst1");
    check("rst_flush_lit", int'(o_flush), 4'hF);
    reset_n = 1'b1;
    cyc("idle");

    // Forwarding
    hz.RegWriteM = 1; hz.WA3M = 3; hz.RA1E = 3; hz.RegWriteW = 1; hz.WA3W = 3; hz.RA2E = 3;
    cyc("fwd_mw");
    check("fwd_m_beats_w_lit", int'(o_fa), 2);
    hz.RA1E = 15;
    cyc("fwd_pc");
    check("fwd_pc_lit", int'(o_fa), 0);
    hz.RegWriteM = 0; hz.RA1E = 3;
    cyc("fwd_w");
    check("fwd_w_lit", int'(o_fa), 1);
    hz.RegWriteM = 1; hz.RA2E = 4; hz.WA3W = 4;
    cyc("fwd_ab");
    check("fwd_b_w_lit", int'(o_fb), 1);
    idle_inputs();

    // Load-use: exactly one bubble, even with the hazard inputs held
    hz.MemtoRegE = 1; hz.WA3E = 5; hz.RA2D = 5;
    cyc("ldu0");
    check("ldu_stall_lit", int'(o_stall), 4'b0011);
    check("ldu_flush_lit", int'(o_flush), 4'b0010);
    cyc("ldu1");
    check("ldu_release_lit", int'(o_stall | o_flush), 0);
    idle_inputs();
    cyc("idle");
    hz.MemtoRegE = 1; hz.WA3E = 15; hz.RA1D = 15;
    cyc("ldu_pc");
    idle_inputs();

    // Memory wait of three cycles
    hz.MemReqM = 1; hz.MemReady = 0; cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc("mwait");
      if (o_stall == 4'hF && o_flush[3]) cnt++;
    end
    hz.MemReady = 1;
    cyc("mready");
    if (o_stall == 4'hF) cnt++;
    check("mwait_cycles_lit", cnt, 3);
    idle_inputs();
    cyc("idle");
    hz.MemReqM = 1; hz.MemReady = 1;
    cyc("mzero");
    idle_inputs();

    // Load-use during a memory wait: no extra bubble on release
    hz.MemReqM = 1; hz.MemReady = 0; hz.MemtoRegE = 1; hz.WA3E = 6; hz.RA1D = 6;
    cyc("mw_ldu0");
    cyc("mw_ldu1");
    hz.MemReady = 1;
    cyc("mw_ldu_rel");
    check("mw_ldu_nobubble_lit", int'(o_stall | o_flush), 0);
    idle_inputs();
    cyc("idle");

    // Timeout: memory never answers
    hz.MemReqM = 1; hz.MemReady = 0; cnt = 0;
    for (int i = 0; i < MT; i++) begin
      cyc("tmo");
      if (o_stall == 4'hF) cnt++;
    end
    check("tmo_stall_cycles_lit", cnt, MT - 1);
    idle_inputs();
    cyc("tmo_after");
    check("tmo_err_lit", int'(o_err), 1);
    cyc("idle");

    // Squash while waiting on memory
    hz.MemReqM = 1; hz.MemReady = 0;
    cyc("sq_mw0");
    cyc("sq_mw1");
    hz.PCSrcW = 1;
    cyc("sq_hit");
    check("sq_abort_lit", int'(o_abort), 1);
    check("sq_flush_lit", int'(o_flush), 4'b0111);
    idle_inputs();
    cyc("sq_next");
    check("sq_next_flushd_lit", int'(o_flush), 4'b0001);
    cyc("sq_run");
    check("sq_run_lit", int'(o_flush), 0);
    hz.PCSrcW = 1;
    cyc("sq_nomem");
    check("sq_nomem_abort_lit", int'(o_abort), 0);
    idle_inputs();
    cyc("idle");

    // Reset in the middle of a memory wait
    hz.MemReqM = 1; hz.MemReady = 0;
    cyc("rmw0");
    cyc("rmw1");
    reset_n = 1'b0;
    cyc("rmw_rst");
    check("rmw_rst_flush_lit", int'(o_flush), 4'hF);
    check("rmw_rst_abort_lit", int'(o_abort), 0);
    reset_n = 1'b1;
    idle_inputs();
    cyc("rmw_after");
    check("rmw_err_clr_lit", int'(o_err), 0);
    check("rmw_run_lit", int'(o_flush | o_stall), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
